// File: rtl/pipe_credit_pkg.sv
// Shared types and helpers for the credit-managed pipeline receive FIFO.
package pipe_credit_pkg;

  localparam int unsigned DefaultDepth = 4;

  // Index field is wide enough for any supported depth (up to 256 entries).
  localparam int unsigned PtrIdxW = 8;

  typedef logic [PtrIdxW-1:0] ptr_idx_t;

  typedef struct packed {
    logic     wrap;
    ptr_idx_t idx;
  } ptr_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer, wrapping the index at depth-1 and flipping the wrap bit.
  function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned depth);
    ptr_t n;
    if (int'(p.idx) == int'(depth) - 1) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + ptr_idx_t'(1);
      n.wrap = p.wrap;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_credit_counter.sv
// Saturating credit counter: resets to DEPTH, decrements on granted issue, increments on pop.
module pipe_credit_counter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic             ok,
  output logic [CNT_W-1:0] value,
  output logic             err
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] value_q, value_d;
  logic             dec_go, inc_sat;

  always_comb begin
    ok      = (value_q != '0);
    dec_go  = dec & ok;
    inc_sat = inc & ~dec_go & (value_q == MaxVal);
    value_d = value_q;
    if (dec_go && !inc) begin
      value_d = value_q - One;
    end else if (inc && !dec_go && !inc_sat) begin
      value_d = value_q + One;
    end
    // Issue without credit and a pop beyond DEPTH both indicate protocol misuse.
    err = (dec & ~ok) | inc_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= MaxVal;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_credit_rx_fifo.sv
// Receive FIFO for a valid-only pipeline, with credit-based issue control upstream.
module pipe_credit_rx_fifo
  import pipe_credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  output logic                  issue_ok,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      credits,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t                  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  empty, full, push, pop, drop, cnt_err;

  always_comb begin
    empty = (rd_q == wr_q);
    full  = (rd_q.idx == wr_q.idx) && (rd_q.wrap != wr_q.wrap);
    pop   = ~empty & out_ready;
    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    push  = in_valid & (~full | pop);
    drop  = in_valid & full & ~pop;

    rd_d    = pop  ? ptr_inc(rd_q, DEPTH) : rd_q;
    wr_d    = push ? ptr_inc(wr_q, DEPTH) : wr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + One;
    end else if (pop && !push) begin
      count_d = count_q - One;
    end
    overflow_d = overflow_q | drop | cnt_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q.idx[AW-1:0]] <= in_data;
    end
  end

  pipe_credit_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (issue),
    .inc   (pop),
    .ok    (issue_ok),
    .value (credits),
    .err   (cnt_err)
  );

  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_q.idx[AW-1:0]];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipe_credit_rx_fifo.sv
// Directed self-checking bench for pipe_credit_rx_fifo at DEPTH=4, DATA_WIDTH=32.
module tb_pipe_credit_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue, issue_ok;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count, credits;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_credit_rx_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .issue_ok  (issue_ok),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .credits   (credits),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    issue     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue n transactions, wait, then deliver n results starting at 0x11.
  task automatic fill(input int n);
    issue = 1'b1;
    for (int i = 0; i < n; i++) tick();
    issue = 1'b0;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (i + 1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (credits !== 3'd4) begin
      n_fail++; $display("FAIL reset_credits: got %0d expected 4", credits);
    end
    n_checks++;
    if (issue_ok !== 1'b1) begin
      n_fail++; $display("FAIL reset_issue_ok: got %b expected 1", issue_ok);
    end
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_credit_fill_drain();
    logic [31:0] exp;
    do_reset();
    issue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (credits !== 3'(4 - i)) begin
        n_fail++; $display("FAIL issue_credits[%0d]: got %0d expected %0d", i, credits, 4 - i);
      end
      tick();
    end
    issue = 1'b0;
    n_checks++;
    if (credits !== 3'd0 || issue_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL credits_exhausted: got credits=%0d ok=%b expected 0/0", credits, issue_ok);
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (i + 1);
      tick();
      n_checks++;
      if (count !== 3'(i + 1)) begin
        n_fail++; $display("FAIL push_count[%0d]: got %0d expected %0d", i, count, i + 1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data,
                 exp);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (credits !== 3'd4 || count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_final: got cr=%0d cnt=%0d v=%b ovf=%b expected 4/0/0/0", credits, count,
               out_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    do_reset();
    fill(4);
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    n_checks++;
    if (out_data !== 32'h11) begin
      n_fail++; $display("FAIL fullpp_head: got %h expected 00000011", out_data);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL fullpp_count: got %0d expected 4", count);
    end
    // Account for the 0x55 transaction's credit so the bookkeeping stays legal.
    issue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i == 3) ? 32'h55 : 32'h11 * (i + 2);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++;
        $display("FAIL fullpp_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid,
                 out_data, exp);
      end
      tick();
      issue = 1'b0;
    end
    out_ready = 1'b0;
    n_checks++;
    if (credits !== 3'd4 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_final: got cr=%0d ovf=%b v=%b expected 4/0/0", credits, overflow,
               out_valid);
    end
  endtask

  task automatic test_overflow_drop();
    logic [31:0] exp;
    do_reset();
    fill(4);
    in_valid = 1'b1;
    in_data  = 32'h66;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL drop_flag: got ovf=%b cnt=%0d expected 1/4", overflow, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      n_checks++;
      if (out_data !== exp) begin
        n_fail++; $display("FAIL drop_drain[%0d]: got %h expected %h", i, out_data, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_final: got v=%b ovf=%b expected 0/1", out_valid, overflow);
    end
  endtask

  task automatic test_credit_underflow();
    do_reset();
    fill(4);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || credits !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow: got ovf=%b cr=%0d expected 1/0", overflow, credits);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (credits !== 3'd1 || overflow !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL underflow_pop: got cr=%0d ovf=%b cnt=%0d expected 1/1/3", credits, overflow,
               count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(3);
    n_checks++;
    if (count !== 3'd3 || credits !== 3'd1) begin
      n_fail++; $display("FAIL mid_pre: got cnt=%0d cr=%0d expected 3/1", count, credits);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || credits !== 3'd4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got cnt=%0d cr=%0d v=%b expected 0/4/0", count, credits,
               out_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'hA5;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_push: got v=%b d=%h cnt=%0d expected 1/000000a5/1", out_valid, out_data,
               count);
    end
  endtask

  initial begin
    test_reset();
    test_credit_fill_drain();
    test_full_push_pop();
    test_overflow_drop();
    test_credit_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_credit_rx_fifo.md
Name: pipe_credit_rx_fifo

Overview:
- Receive-side endpoint for a valid-only (no backpressure) pipeline. It captures each result the pipeline presents with its valid strobe and re-issues it to downstream logic on a ready/valid handshake.
- It also tells the upstream issuer whether it may launch a new transaction into the pipeline. A credit counter reserves a FIFO slot for every in-flight transaction, so results are never dropped under correct use.
- Sits between a generated pipeline's output (data plus out_valid) and a backpressuring consumer.

Parameters:
- DATA_WIDTH, 32, width of pipeline result and FIFO entry.
- DEPTH, 4, FIFO entries and initial credits; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy and credit counters (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- issue  input  1  upstream launches one transaction into the pipeline this cycle.
- issue_ok  output  1  a credit is available; issue is legal this cycle.
- in_valid  input  1  pipeline result valid (pipeline out_valid).
- in_data  input  DATA_WIDTH  pipeline result.
- out_valid  output  1  FIFO head valid.
- out_data  output  DATA_WIDTH  FIFO head data.
- out_ready  input  1  downstream accepts head.
- count  output  CNT_W  entries currently stored.
- credits  output  CNT_W  free credits.
- overflow  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, release synchronous to clk): count=0, credits=DEPTH, out_valid=0, overflow=0, pointers=0. out_data is don't-care while out_valid=0.
- Storage: register array plus rd/wr pointers, each one bit wider than log2(DEPTH) for the wrap flag. Empty when pointers are equal. Full when the index bits are equal and the wrap bits differ. Pointers wrap DEPTH-1 to 0 naturally.
- Push: in_valid=1 and (not full, or pop in the same cycle) writes mem[wr_ptr].
- Pop: out_valid and out_ready.
- Full with simultaneous push and pop: both happen; count is unchanged.
- Latency: in_valid at edge N gives out_valid=1 with the data after edge N, when the FIFO was empty. out_valid equals not-empty; out_data is mem[rd_ptr], driven from registers only (no combinational in-to-out path).
- Simultaneous push and pop on an empty FIFO: not possible, because out_valid=0 then. The push proceeds alone.
- Credits:
  - credits_next = credits − (issue and issue_ok) + pop.
  - issue_ok = (credits != 0), combinational from the register.
  - Issue and pop in the same cycle: net change is 0.
  - Invariant under legal use: credits + count + inflight = DEPTH.
- Error cases, each sets overflow (sticky until reset):
  - issue while issue_ok=0: credits stay 0, with no underflow.
  - in_valid while full and no pop: data is dropped, and pointers and count are unchanged.
  - A pop that would take credits above DEPTH: saturate at DEPTH. This is only reachable after an error.
- Reset mid-operation: all stored and in-flight data is discarded and credits return to DEPTH. Results arriving after reset release are treated as normal pushes.
- No internal FSM beyond the counters. The output stage is a simple EMPTY/NONEMPTY condition derived from the pointers.

Decomposition:
- Shared package pipe_credit_pkg holds:
  - a function returning the credit/count width for a given depth;
  - a localparam for default DEPTH;
  - a typedef for the pointer struct {wrap bit, index}.
- One natural sub-module, pipe_credit_counter: a saturating up/down counter with reset value DEPTH, decrement gated by issue_ok, and an error output. The FIFO storage and pointers stay in the top module.

Test Plan (DEPTH=4, DATA_WIDTH=32):
- Reset then idle: credits=4, issue_ok=1, count=0, out_valid=0, overflow=0.
- Issue 4 transactions on consecutive cycles, out_ready=0: credits 4→3→2→1→0 and issue_ok=0. Then results 0x11, 0x22, 0x33, 0x44 arrive 2 cycles later: count reaches 4. Raise out_ready: outputs appear in order, one per cycle. credits returns to 4 and overflow stays 0.
- Full FIFO (count=4), in_valid=1 with data 0x55 while out_ready=1: pop 0x11 and push 0x55 in the same cycle. count stays 4, and the subsequent drain order is 0x22, 0x33, 0x44, 0x55.
- Full FIFO, in_valid=1 with data 0x66, out_ready=0: overflow=1 from the next cycle, count=4, and 0x66 never appears on out_data.
- credits=0 and issue=1: overflow=1 and credits stays 0. Then a pop makes credits=1, while overflow remains 1.
- With count=3, deassert rst_n mid-cycle: outputs clear asynchronously (count=0, credits=4, out_valid=0). After release, push 0xA5: out_valid=1 and out_data=0xA5 one cycle later.
